// File: rtl/ram_bus_bridge.sv
// CPU fetch/data port arbiter and SRAM driver sequencer.
// Word addressing, sub-word read-modify-write, ack watchdog.
module ram_bus_bridge #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall_req,
  output logic        bus_err,
  output logic        ram_enable,
  output logic        ram_read_enable,
  output logic        ram_write_enable,
  output logic [20:0] ram_addr,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out,
  input  logic        ram_ack
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_RMW_RD_REQ,
    S_RMW_RD_WAIT,
    S_RMW_WR_REQ,
    S_RMW_WR_WAIT,
    S_DONE
  } state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        port_mem_q;
  logic [3:0]  sel_q;
  logic [7:0]  cnt_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic        bus_err_q;
  logic        en_q;
  logic        rd_stb_q;
  logic        wr_stb_q;
  logic [20:0] addr_q;
  logic [31:0] din_q;

  logic [31:0] merge_d;
  logic        grant_ok;
  logic        last_rd;
  logic        rmw_rd;

  // No new grant while a completion pulse is still on the CPU side.
  assign grant_ok = ~(if_ready_q | mem_ready_q);
  assign last_rd  = (state_q == S_RD_WAIT);
  assign rmw_rd   = (state_q == S_RMW_RD_WAIT);

  // Merge store lanes over the word just read back; din_q holds wdata.
  always_comb begin
    merge_d = 32'h0;
    for (int i = 0; i < 4; i++) begin
      merge_d[8*i +: 8] = sel_q[i] ? din_q[8*i +: 8]
                                   : ram_data_out[8*i +: 8];
    end
  end

  // Transaction sequencer with registered strobes, readies and data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      port_mem_q  <= 1'b0;
      sel_q       <= 4'h0;
      cnt_q       <= 8'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      en_q        <= 1'b0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      addr_q      <= 21'h0;
      din_q       <= 32'h0;
    end else begin
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_ok && mem_req) begin
            if (!mem_we) begin
              state_q    <= S_RD_REQ;
              port_mem_q <= 1'b1;
              addr_q     <= mem_addr[22:2];
              rd_stb_q   <= 1'b1;
              en_q       <= 1'b1;
            end else if (mem_sel == 4'hF) begin
              state_q    <= S_WR_REQ;
              port_mem_q <= 1'b1;
              addr_q     <= mem_addr[22:2];
              din_q      <= mem_wdata;
              wr_stb_q   <= 1'b1;
              en_q       <= 1'b1;
            end else if (mem_sel == 4'h0) begin
              mem_ready_q <= 1'b1;
            end else begin
              state_q    <= S_RMW_RD_REQ;
              port_mem_q <= 1'b1;
              addr_q     <= mem_addr[22:2];
              din_q      <= mem_wdata;
              sel_q      <= mem_sel;
              rd_stb_q   <= 1'b1;
              en_q       <= 1'b1;
            end
          end else if (grant_ok && if_req) begin
            state_q    <= S_RD_REQ;
            port_mem_q <= 1'b0;
            addr_q     <= if_addr[22:2];
            rd_stb_q   <= 1'b1;
            en_q       <= 1'b1;
          end
        end
        S_RD_REQ: begin
          state_q <= S_RD_WAIT;
          cnt_q   <= 8'h0;
        end
        S_WR_REQ: begin
          state_q <= S_WR_WAIT;
          cnt_q   <= 8'h0;
        end
        S_RMW_RD_REQ: begin
          state_q <= S_RMW_RD_WAIT;
          cnt_q   <= 8'h0;
        end
        S_RMW_WR_REQ: begin
          state_q <= S_RMW_WR_WAIT;
          cnt_q   <= 8'h0;
        end
        S_RD_WAIT, S_WR_WAIT, S_RMW_RD_WAIT, S_RMW_WR_WAIT: begin
          if (ram_ack) begin
            cnt_q <= 8'h0;
            if (rmw_rd) begin
              state_q  <= S_RMW_WR_REQ;
              din_q    <= merge_d;
              wr_stb_q <= 1'b1;
            end else begin
              state_q     <= S_DONE;
              en_q        <= 1'b0;
              if_ready_q  <= ~port_mem_q;
              mem_ready_q <= port_mem_q;
              if (last_rd && port_mem_q) begin
                mem_rdata_q <= ram_data_out;
              end else if (last_rd) begin
                if_rdata_q <= ram_data_out;
              end
            end
          end else if (cnt_q == CntLast) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'h0;
            en_q        <= 1'b0;
            bus_err_q   <= 1'b1;
            if_ready_q  <= ~port_mem_q;
            mem_ready_q <= port_mem_q;
            if (port_mem_q) begin
              mem_rdata_q <= 32'h0;
            end else begin
              if_rdata_q <= 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata         = if_rdata_q;
  assign if_ready         = if_ready_q;
  assign mem_rdata        = mem_rdata_q;
  assign mem_ready        = mem_ready_q;
  assign bus_err          = bus_err_q;
  assign ram_enable       = en_q;
  assign ram_read_enable  = rd_stb_q;
  assign ram_write_enable = wr_stb_q;
  assign ram_addr         = addr_q;
  assign ram_data_in      = din_q;
  assign stall_req        = rst & (if_req | mem_req)
                            & ~(if_ready_q | mem_ready_q);

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Bench for ram_bus_bridge: vector table, corner sequences,
// and randomized traffic against a word-array reference.
module tb_ram_bus_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = 4'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_req;
  logic        bus_err;
  logic        ram_enable;
  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [20:0] ram_addr;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out = 32'h0;
  logic        ram_ack = 1'b0;

  always #5 clk = ~clk;

  ram_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_req(stall_req), .bus_err(bus_err),
    .ram_enable(ram_enable),
    .ram_read_enable(ram_read_enable),
    .ram_write_enable(ram_write_enable),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_ack(ram_ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] k;
    k = 32'(i + 1);
    return (k * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  // ---------------- SRAM driver model ----------------
  logic [31:0] drv_mem [128];
  bit          no_ack = 1'b0;
  bit          rand_lat = 1'b0;
  int          fix_lat = 3;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_word = 32'h0;
  int          drv_cnt = 0;
  bit          drv_busy = 1'b0;
  bit          drv_we = 1'b0;

  function automatic logic [6:0] widx(input logic [20:0] a);
    return {a[20], a[5:0]};
  endfunction

  always @(posedge clk) begin
    ram_ack <= 1'b0;
    if (!rst) begin
      drv_busy <= 1'b0;
      for (int i = 0; i < 128; i++) drv_mem[i] <= init_word(i);
    end else if (drv_busy) begin
      if (drv_cnt <= 1) begin
        ram_ack  <= 1'b1;
        drv_busy <= 1'b0;
        if (drv_we) drv_mem[widx(ram_addr)] <= ram_data_in;
        else ram_data_out <= ovr_en ? ovr_word : drv_mem[widx(ram_addr)];
      end else begin
        drv_cnt <= drv_cnt - 1;
      end
    end else if ((ram_read_enable || ram_write_enable) && !no_ack) begin
      drv_busy <= 1'b1;
      drv_we   <= ram_write_enable;
      drv_cnt  <= rand_lat ? int'($urandom_range(1, 4)) : fix_lat - 1;
    end
  end

  // ---------------- strobe monitor ----------------
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [20:0] rd_log [8];
  logic [20:0] wr_addr_last = 21'h0;
  logic [31:0] wr_data_last = 32'h0;

  always @(posedge clk) begin
    if (ram_read_enable) begin
      rd_log[3'(rd_cnt)] <= ram_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (ram_write_enable) begin
      wr_addr_last <= ram_addr;
      wr_data_last <= ram_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------- single transaction ----------------
  task automatic run_txn(input bit is_mem, input bit we,
                         input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         output logic [31:0] rdata, output int cyc,
                         output bit berr, output bit stall_ok,
                         output bit en_off);
    @(negedge clk);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_sel = sel;
      mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    cyc = 0; stall_ok = 1'b1; rdata = 32'h0;
    berr = 1'b0; en_off = 1'b0;
    #1;
    if (!stall_req) stall_ok = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (is_mem ? mem_ready : if_ready) begin
        rdata  = is_mem ? mem_rdata : if_rdata;
        berr   = bus_err;
        en_off = !ram_enable;
        if (stall_req) stall_ok = 1'b0;
        break;
      end
      if (!stall_req) stall_ok = 1'b0;
    end
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_word;
    logic [20:0] exp_addr;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [6:0] ridx(input logic [31:0] a);
    return {a[22], a[7:2]};
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old,
                                            input logic [31:0] w,
                                            input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (w & m) | (old & ~m);
  endfunction

  logic [31:0] ref_mem [128];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          cyc;
    bit          be, st, eo;
    int          b_rd, b_wr;
    int          mem_t, if_t;
    bit          if_out, mem_out;

    tbl[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h2408_0001,
               21'h40, 1, 0, 32'h0, 32'h2408_0001, 5};
    tbl[1] = '{1'b1, 1'b0, 4'hF, 32'h0040_0008, 32'h0, 32'hCAFE_F00D,
               21'h10_0002, 1, 0, 32'h0, 32'hCAFE_F00D, 5};
    tbl[2] = '{1'b1, 1'b1, 4'b0010, 32'h0000_0204, 32'h0000_AB00,
               32'h1122_3344, 21'h81, 1, 1, 32'h1122_AB44, 32'h0, 9};
    tbl[3] = '{1'b1, 1'b1, 4'hF, 32'hFF80_0010, 32'hDEAD_BEEF,
               32'h0, 21'h4, 0, 1, 32'hDEAD_BEEF, 32'h0, 5};
    tbl[4] = '{1'b1, 1'b1, 4'h0, 32'h0000_0300, 32'h1234_5678,
               32'h0, 21'h0, 0, 0, 32'h0, 32'h0, 1};
    tbl[5] = '{1'b1, 1'b1, 4'b1100, 32'h007F_FFFF, 32'h5566_0000,
               32'hAAAA_BBBB, 21'h1F_FFFF, 1, 1, 32'h5566_BBBB, 32'h0, 9};
    tbl[6] = '{1'b1, 1'b1, 4'b1001, 32'h0000_0010, 32'h12AA_AA34,
               32'hFFFF_FFFF, 21'h4, 1, 1, 32'h12FF_FF34, 32'h0, 9};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 32'h0000_0003, 32'h0, 32'h0BAD_F00D,
               21'h0, 1, 0, 32'h0, 32'h0BAD_F00D, 5};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst0_data", if_rdata | mem_rdata | ram_data_in, 32'h0);
    chk("rst0_addr", 32'(ram_addr), 32'h0);
    chk("rst0_flags", 32'({if_ready, mem_ready, stall_req, bus_err,
        ram_enable, ram_read_enable, ram_write_enable}), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // vector table
    fix_lat = 3;
    ovr_en = 1'b1;
    foreach (tbl[i]) begin
      ovr_word = tbl[i].ram_word;
      b_rd = rd_cnt; b_wr = wr_cnt;
      run_txn(tbl[i].is_mem, tbl[i].we, tbl[i].sel, tbl[i].addr,
              tbl[i].wdata, rd, cyc, be, st, eo);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
      chk($sformatf("v%0d_rd_strobes", i), 32'(rd_cnt - b_rd),
          32'(tbl[i].exp_rd));
      chk($sformatf("v%0d_wr_strobes", i), 32'(wr_cnt - b_wr),
          32'(tbl[i].exp_wr));
      chk($sformatf("v%0d_stall", i), 32'(st), 32'h1);
      chk($sformatf("v%0d_en_off", i), 32'(eo), 32'h1);
      chk($sformatf("v%0d_bus_err", i), 32'(be), 32'h0);
      if (tbl[i].exp_rd > 0)
        chk($sformatf("v%0d_rd_addr", i), 32'(rd_log[3'(rd_cnt - 1)]),
            32'(tbl[i].exp_addr));
      if (tbl[i].exp_wr > 0) begin
        chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr_last),
            32'(tbl[i].exp_addr));
        chk($sformatf("v%0d_din", i), wr_data_last, tbl[i].exp_din);
      end
      if (!tbl[i].we)
        chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rdata);
    end

    // conflict: data port first, then fetch
    @(negedge clk);
    ovr_word = 32'h1111_2222;
    b_rd = rd_cnt;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0040_0008;
    mem_t = -1; if_t = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (mem_ready) begin mem_t = c; mem_req = 1'b0; end
      if (if_ready) begin if_t = c; if_req = 1'b0; end
      if (mem_t >= 0 && if_t >= 0) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("conf_mem_time", 32'(mem_t), 32'd5);
    chk("conf_if_time", 32'(if_t), 32'd11);
    chk("conf_addr0", 32'(rd_log[3'(b_rd)]), 32'h10_0002);
    chk("conf_addr1", 32'(rd_log[3'(b_rd + 1)]), 32'h40);
    chk("conf_if_rdata", if_rdata, 32'h1111_2222);

    // watchdog: driver never acks
    no_ack = 1'b1;
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, rd, cyc, be, st, eo);
    chk("to_cycles", 32'(cyc), 32'd18);
    chk("to_bus_err", 32'(be), 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_en_off", 32'(eo), 32'h1);
    @(negedge clk);
    chk("to_after", 32'({ram_enable, bus_err, mem_ready}), 32'h0);
    no_ack = 1'b0;

    // ack one cycle too late: abort, late ack ignored
    fix_lat = 17; ovr_word = 32'h5A5A_0001;
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0, rd, cyc, be, st, eo);
    chk("late_cycles", 32'(cyc), 32'd18);
    chk("late_bus_err", 32'(be), 32'h1);
    chk("late_rdata", rd, 32'h0);

    // ack on the last allowed wait cycle wins
    fix_lat = 16; ovr_word = 32'h5A5A_0002;
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0048, 32'h0, rd, cyc, be, st, eo);
    chk("edge_cycles", 32'(cyc), 32'd18);
    chk("edge_bus_err", 32'(be), 32'h0);
    chk("edge_rdata", rd, 32'h5A5A_0002);

    // service resumes normally
    fix_lat = 3; ovr_word = 32'h2408_0001;
    run_txn(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, rd, cyc, be, st, eo);
    chk("resume_cycles", 32'(cyc), 32'd5);
    chk("resume_rdata", rd, 32'h2408_0001);
    chk("resume_bus_err", 32'(be), 32'h0);

    // request withdrawn mid-transaction still completes
    ovr_word = 32'h7777_0008;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0008;
    if_t = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2) if_req = 1'b0;
      if (if_ready) begin if_t = c; break; end
    end
    chk("wd_ready_time", 32'(if_t), 32'd5);
    chk("wd_rdata", if_rdata, 32'h7777_0008);

    // reset during RMW read wait
    fix_lat = 10; ovr_word = 32'h1122_3344;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0010;
    mem_addr = 32'h0000_0204; mem_wdata = 32'h0000_AB00;
    repeat (3) @(negedge clk);
    chk("rr_in_wait", 32'({ram_enable, ram_read_enable}), 32'h2);
    b_rd = rd_cnt; b_wr = wr_cnt;
    rst = 1'b0;
    #1;
    chk("rr_if_rdata", if_rdata, 32'h0);
    chk("rr_mem_rdata", mem_rdata, 32'h0);
    chk("rr_ram_addr", 32'(ram_addr), 32'h0);
    chk("rr_ram_din", ram_data_in, 32'h0);
    chk("rr_flags", 32'({if_ready, mem_ready, stall_req, bus_err,
        ram_enable, ram_read_enable, ram_write_enable}), 32'h0);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("rr_no_strobes", 32'((rd_cnt - b_rd) + (wr_cnt - b_wr)), 32'h0);
    fix_lat = 3; ovr_word = 32'h0BAD_CAFE;
    run_txn(1'b0, 1'b0, 4'h0, 32'h0000_0200, 32'h0, rd, cyc, be, st, eo);
    chk("rr_fetch_rdata", rd, 32'h0BAD_CAFE);
    chk("rr_fetch_cycles", 32'(cyc), 32'd5);

    // randomized traffic against reference memory
    ovr_en = 1'b0;
    rand_lat = 1'b1;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    if_out = 1'b0; mem_out = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (if_ready) begin
        chk("rnd_if_owner", 32'(if_out), 32'h1);
        chk("rnd_if_berr", 32'(bus_err), 32'h0);
        chk("rnd_fetch", if_rdata, ref_mem[ridx(if_addr)]);
        if_req = 1'b0; if_out = 1'b0;
      end
      if (mem_ready) begin
        chk("rnd_mem_owner", 32'(mem_out), 32'h1);
        chk("rnd_mem_berr", 32'(bus_err), 32'h0);
        if (!mem_we)
          chk("rnd_load", mem_rdata, ref_mem[ridx(mem_addr)]);
        else
          ref_mem[ridx(mem_addr)] =
            ref_merge(ref_mem[ridx(mem_addr)], mem_wdata, mem_sel);
        mem_req = 1'b0; mem_out = 1'b0;
      end
      if (c < 2800) begin
        if (!if_out && $urandom_range(0, 3) == 0) begin
          if_addr = $urandom;
          if_req = 1'b1; if_out = 1'b1;
        end
        if (!mem_out && $urandom_range(0, 2) == 0) begin
          mem_addr = $urandom;
          mem_wdata = $urandom;
          mem_we = 1'($urandom_range(0, 1));
          mem_sel = 4'($urandom_range(0, 15));
          mem_req = 1'b1; mem_out = 1'b1;
        end
      end
    end
    chk("rnd_drained", 32'({if_out, mem_out}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_bridge.md
Name: ram_bus_bridge

Overview:
- Sits between the CPU (instruction-fetch port and data-memory port) and the word-wide SRAM driver.
- Arbitrates the two CPU ports and converts byte addresses to 21-bit word addresses.
- Performs read-modify-write for sub-word stores.
- Issues single-cycle read/write strobes to the driver and waits for its ack pulse, with a watchdog timeout.
- Stalls the CPU while a transaction is outstanding.

Parameters:
- TIMEOUT, 64: cycles to wait for ram_ack after a strobe before aborting the access (valid range 8..255).

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch data, valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- mem_req  in  1  data request, held until mem_ready
- mem_we  in  1  1=store, 0=load
- mem_sel  in  4  byte enables; bit i selects data[8i+7:8i]
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data, byte lanes aligned to mem_sel
- mem_rdata  out  32  load data (full word), valid when mem_ready=1
- mem_ready  out  1  one-cycle completion pulse for data access
- stall_req  out  1  CPU pipeline stall
- bus_err  out  1  one-cycle pulse on watchdog abort
- ram_enable  out  1  driver enable, high while a transaction is in flight
- ram_read_enable  out  1  single-cycle read strobe
- ram_write_enable  out  1  single-cycle write strobe
- ram_addr  out  21  word address to driver; bit 20 selects extram
- ram_data_in  out  32  write data to driver
- ram_data_out  in  32  read data from driver, valid when ram_ack=1
- ram_ack  in  1  one-cycle completion pulse from driver

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0 (if_rdata, mem_rdata, ram_addr and ram_data_in all zero); watchdog counter=0.
- Address mapping: ram_addr = addr[22:2]. Bits [31:23] and [1:0] are ignored.
- Arbitration, sampled in IDLE only: mem_req beats if_req. A request arriving mid-transaction waits; requests are never dropped.
- stall_req = combinational (if_req | mem_req) & ~(if_ready | mem_ready).
- Strobe rule:
  - read/write strobe high for exactly the one cycle in a *_REQ state.
  - ram_addr and ram_data_in are registered on entry to *_REQ and held unchanged until ram_ack or abort.
  - ram_enable is high from *_REQ through the cycle ram_ack is seen.
- State machine:
  - IDLE -> RD_REQ on (mem_req & ~mem_we) or (if_req & ~mem_req).
  - IDLE -> WR_REQ on mem_req & mem_we & mem_sel==4'b1111.
  - IDLE -> RMW_RD_REQ on mem_req & mem_we & mem_sel!=4'b1111.
  - mem_sel==0 store: completes in IDLE, with mem_ready pulsed the next cycle and no RAM access.
  - RD_REQ -> RD_WAIT. On RD_WAIT & ram_ack: capture ram_data_out into if_rdata or mem_rdata (per the granted port) -> DONE.
  - WR_REQ -> WR_WAIT. On WR_WAIT & ram_ack -> DONE.
  - RMW_RD_REQ -> RMW_RD_WAIT. On ram_ack: merge word = per lane i, mem_sel[i] ? mem_wdata lane : ram_data_out lane; the merged word goes to ram_data_in -> RMW_WR_REQ.
  - RMW_WR_REQ -> RMW_WR_WAIT. On ram_ack -> DONE.
  - DONE: pulse if_ready or mem_ready for one cycle (granted port only) -> IDLE. Next grant is earliest the cycle after DONE.
- Watchdog:
  - Counter clears on entry to any *_WAIT state and increments each WAIT cycle.
  - On reaching TIMEOUT without ram_ack: pulse bus_err together with the granted port's ready; data output = 32'h0; ram_enable drops; state goes to IDLE.
  - A ram_ack in any non-WAIT state is ignored.
- Ack and timeout coinciding: in the same cycle, ack wins and bus_err stays 0.
- Reset mid-transaction: FSM returns to IDLE immediately and strobes drop. The CPU must re-issue the request.
- Request withdrawn mid-transaction (CPU drops req): the transaction still completes and the ready pulse is still issued.

Test Plan:
- Fetch: if_req=1, if_addr=32'h0000_0100, driver returns 32'h2408_0001 three cycles after the strobe -> ram_addr=21'h40, exactly one ram_read_enable cycle, if_rdata=32'h2408_0001, single if_ready pulse, stall_req=1 throughout and 0 on the ready cycle.
- Conflict: if_req and mem_req(load, mem_addr=32'h0040_0008) raised in the same cycle -> data served first (ram_addr=21'h10_0002, bit20=1), then fetch; two ready pulses in order mem then if.
- Byte store: mem_sel=4'b0010, mem_wdata=32'h0000_AB00, RAM word=32'h1122_3344 -> one read strobe, then one write strobe with ram_data_in=32'h1122_AB44, then mem_ready.
- Full store: mem_sel=4'hF, mem_wdata=32'hDEAD_BEEF -> no read strobe, one write strobe, ram_data_in=32'hDEAD_BEEF; mem_sel=0 store -> mem_ready with no strobes.
- Timeout: TIMEOUT=16, driver never acks -> bus_err and mem_ready pulse on the 16th wait cycle, mem_rdata=0, ram_enable low next cycle; a new request is then served normally.
- Reset: rst=0 asserted during RMW_RD_WAIT -> all outputs 0 asynchronously; after release, no strobe appears until a new request.
